// File: rtl/sele_pkg.sv
// sele_pkg: shared types and helpers for the sele_rr_mux streaming selector.
// Optional build macro: SELE_REVERSE_ORDER_EN (fixed-mode sel maps to channel N-1-sel).
package sele_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Round-robin pointer successor: the channel after g, wrapping N-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
  endfunction

  // Physical channel addressed by a fixed-mode sel; returns n when sel selects nothing.
  function automatic int unsigned chan_map(input int unsigned sel, input int unsigned n);
`ifdef SELE_REVERSE_ORDER_EN
    return (sel < n) ? (n - 32'd1 - sel) : n;
`else
    return (sel < n) ? sel : n;
`endif
  endfunction

endpackage

// File: rtl/sele_rr_arb.sv
// sele_rr_arb: rotating-priority arbiter; grants the first requester at or after ptr.
module sele_rr_arb #(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant
);

  logic [N-1:0]   req_rot;
  logic [N-1:0]   grant_rot;
  logic [2*N-1:0] grant_back;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate the pick back.
  always_comb begin
    req_rot    = N'({req, req} >> ptr);
    grant_rot  = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (req_rot[j] && (grant_rot == '0)) begin
        grant_rot[j] = 1'b1;
      end
    end
    grant_back = {grant_rot, grant_rot} << ptr;
    grant      = grant_back[2*N-1:N];
  end

endmodule

// File: rtl/sele_rr_mux.sv
// sele_rr_mux: N-channel handshaked selector, fixed-select or round-robin,
// with a single registered output word tagged by its source channel.
// Optional build macro: SELE_REVERSE_ORDER_EN (see sele_pkg::chan_map).
module sele_rr_mux
  import sele_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     rr_grant;
  logic [N-1:0]     fix_grant;
  logic [N-1:0]     grant;
  logic             load_c;
  logic             xfer_c;
  logic [SELW-1:0]  g_idx;
  logic [WIDTH-1:0] g_data;
  int unsigned      fix_chan;

  sele_rr_arb #(.N(N)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  // Fixed-mode grant: only the mapped channel, and only if it is valid.
  always_comb begin
    fix_chan  = chan_map(32'(sel), N);
    fix_grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      fix_grant[i] = in_valid[i] && (fix_chan == i);
    end
  end

  // Handshake: accept only when the output register can take a word, never in reset.
  always_comb begin
    grant    = (mode == MODE_RR) ? rr_grant : fix_grant;
    load_c   = ~out_valid | out_ready;
    in_ready = grant & {N{load_c & ~rst}};
    xfer_c   = |(in_ready & in_valid);
  end

  // Encode the granted channel and select its data word.
  always_comb begin
    g_idx  = '0;
    g_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        g_idx  = SELW'(i);
        g_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: capture on transfer, drain when consumed with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_c) begin
      if (xfer_c) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_chan  <= g_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: advances past the winner on round-robin transfers only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer_c && (mode == MODE_RR)) begin
      ptr <= SELW'(rr_next(32'(g_idx), N));
    end
  end

endmodule

// File: tb/tb_sele_rr_mux.sv
// tb_sele_rr_mux: table vectors, directed corner sequences and a randomized
// run against a behavioural model for sele_rr_mux (N=4, WIDTH=8).
module tb_sele_rr_mux;

`ifdef SELE_REVERSE_ORDER_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs [6];

  // Behavioural model state for the random phase.
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  logic [3:0] eg;
  bit         m_load;

  sele_rr_mux #(.N(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] dat(input int k, input int c);
    return 8'(16 * k + 3 * c + 5);
  endfunction

  // Expected grant from the selection rules: circular search from p, or the mapped sel.
  function automatic logic [3:0] exp_grant(input bit md, input int s, input logic [3:0] v, input int p);
    int c;
    if (md) begin
      for (int k = 0; k < 4; k++) begin
        c = (p + k) % 4;
        if (v[c]) return 4'(1 << c);
      end
      return 4'b0000;
    end
    c = REV ? 3 - s : s;
    return v[c] ? 4'(1 << c) : 4'b0000;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'hF;
    in_data  = 32'h0;
    out_ready = 1'b1;

`ifdef SELE_REVERSE_ORDER_EN
    vecs[0] = '{2'd2, 4'b1111, 4'b0010};
    vecs[1] = '{2'd0, 4'b1000, 4'b1000};
    vecs[2] = '{2'd3, 4'b0111, 4'b0001};
    vecs[3] = '{2'd1, 4'b0010, 4'b0000};
    vecs[4] = '{2'd1, 4'b0100, 4'b0100};
    vecs[5] = '{2'd3, 4'b1110, 4'b0000};
`else
    vecs[0] = '{2'd2, 4'b1111, 4'b0100};
    vecs[1] = '{2'd0, 4'b0001, 4'b0001};
    vecs[2] = '{2'd3, 4'b0111, 4'b0000};
    vecs[3] = '{2'd1, 4'b0010, 4'b0010};
    vecs[4] = '{2'd3, 4'b1000, 4'b1000};
    vecs[5] = '{2'd0, 4'b1110, 4'b0000};
`endif

    // Reset before any clock edge.
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_chan",  32'(out_chan),  32'd0);
    chk("rst_ready", 32'(in_ready),  32'd0);
    cyc();
    rst = 1'b0;

    // Fixed-mode table.
    for (int k = 0; k < 6; k++) begin
      sel      = vecs[k].sel;
      in_valid = vecs[k].valid;
      for (int c = 0; c < 4; c++) in_data[c*8 +: 8] = dat(k, c);
      #1;
      chk("tbl_ready", 32'(in_ready), 32'(vecs[k].exp_ready));
      cyc();
      chk("tbl_valid", 32'(out_valid), 32'(|vecs[k].exp_ready));
      if (vecs[k].exp_ready != 4'b0000) begin
        chk("tbl_data", 32'(out_data), 32'(dat(k, oh2idx(vecs[k].exp_ready))));
        chk("tbl_chan", 32'(out_chan), 32'(oh2idx(vecs[k].exp_ready)));
      end
    end

    // Fixed-mode single transfer, then a reset pulse during a stall.
    in_valid = 4'hF;
`ifdef SELE_REVERSE_ORDER_EN
    sel     = 2'd3;
    in_data = 32'h4433223C;
    #1;
    chk("fix_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("fix_data", 32'(out_data), 32'h3C);
    chk("fix_chan", 32'(out_chan), 32'd0);
`else
    sel     = 2'd2;
    in_data = 32'h44A52211;
    #1;
    chk("fix_ready", 32'(in_ready), 32'h4);
    cyc();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_chan", 32'(out_chan), 32'd2);
`endif
    chk("fix_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    cyc();
    chk("stall_hold", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    chk("midrst_chan",  32'(out_chan),  32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd0);
    in_valid = 4'h0;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("no_reemit", 32'(out_valid), 32'd0);

    // Round-robin with every channel valid: 0,1,2,3,0,1.
    mode     = 1'b1;
    in_valid = 4'hF;
    in_data  = 32'h44332211;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rr_chan",  32'(out_chan),  32'(k % 4));
      chk("rr_data",  32'(out_data),  32'(8'h11 * ((k % 4) + 1)));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Stall three cycles, then resume from ch2.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_chan",  32'(out_chan),  32'd1);
      chk("stall_data",  32'(out_data),  32'h22);
      chk("stall_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("resume_ready", 32'(in_ready), 32'h4);
    cyc();
    chk("resume_chan", 32'(out_chan), 32'd2);

    // Sparse round-robin 1010 from ptr 0, then fixed mode onto an idle channel.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rr_sparse_chan", 32'(out_chan), (k == 1) ? 32'd3 : 32'd1);
    end
    mode = 1'b0;
    sel  = REV ? 2'd3 : 2'd0;
    #1;
    chk("fix_idle_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("fix_idle_valid", 32'(out_valid), 32'd0);

    // Randomized run against the behavioural model.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_chan = 0;
    for (int n = 0; n < 400; n++) begin
      mode      = 1'($urandom_range(1));
      sel       = 2'($urandom_range(3));
      in_valid  = 4'($urandom_range(15));
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
      #1;
      m_load = !m_valid || out_ready;
      eg = m_load ? exp_grant(mode, int'(sel), in_valid, m_ptr) : 4'b0000;
      chk("rand_ready", 32'(in_ready), 32'(eg));
      cyc();
      if (eg != 4'b0000) begin
        m_chan  = oh2idx(eg);
        m_data  = in_data[m_chan*8 +: 8];
        m_valid = 1'b1;
        if (mode) m_ptr = (m_chan + 1) % 4;
      end else if (m_load) begin
        m_valid = 1'b0;
      end
      chk("rand_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rand_data", 32'(out_data), 32'(m_data));
        chk("rand_chan", 32'(out_chan), 32'(m_chan));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
